// File: rtl/fpnew_req_scheduler.sv
// fpnew_req_scheduler: round-robin arbiter sharing one FPU among NumReq requesters with tag-routed responses
module fpnew_req_scheduler #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned MaxOutst = 4,
  parameter type req_t = logic,
  parameter type rsp_t = logic,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  input  req_t              req_i [NumReq],
  output logic [NumReq-1:0] rsp_valid_o,
  input  logic [NumReq-1:0] rsp_ready_i,
  output rsp_t              rsp_o,
  output logic              fpu_in_valid_o,
  input  logic              fpu_in_ready_i,
  output req_t              fpu_req_o,
  output logic [IdxW-1:0]   fpu_tag_o,
  input  logic              fpu_out_valid_i,
  output logic              fpu_out_ready_o,
  input  rsp_t              fpu_rsp_i,
  input  logic [IdxW-1:0]   fpu_tag_i,
  output logic              busy_o
);
  localparam int unsigned CntW = $clog2(MaxOutst + 1);
  logic [CntW-1:0] cnt [NumReq];
  logic lock, found, in_hs, out_hs, tag_ok, sel_ready, active;
  logic [IdxW-1:0] lock_g, rr_ptr, pick, g;
  logic [NumReq-1:0] elig, inc, dec;
  assign active = rst_ni & ~flush_i;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] & (cnt[i] < CntW'(MaxOutst));
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!found && elig[(int'(rr_ptr) + i) % NumReq]) begin
        found = 1'b1;
        pick = IdxW'((int'(rr_ptr) + i) % NumReq);
      end
    end
  end
  // A stalled grant stays pinned to its requester until the FPU accepts it
  assign g = lock ? lock_g : pick;
  assign fpu_in_valid_o = active & (lock ? req_valid_i[lock_g] : found);
  assign fpu_req_o = req_i[g];
  assign fpu_tag_o = g;
  assign in_hs = fpu_in_valid_o & fpu_in_ready_i;
  assign rsp_o = fpu_rsp_i;
  always_comb begin
    tag_ok = 1'b0;
    sel_ready = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      req_ready_o[k] = in_hs & (g == IdxW'(k));
      rsp_valid_o[k] = active & fpu_out_valid_i & (fpu_tag_i == IdxW'(k));
      if (fpu_tag_i == IdxW'(k)) begin
        tag_ok = 1'b1;
        sel_ready = rsp_ready_i[k];
      end
    end
  end
  // Out-of-range tags and flushed responses are sunk so the FPU never stalls on them
  assign fpu_out_ready_o = rst_ni & (flush_i | ~tag_ok | sel_ready);
  assign out_hs = fpu_out_valid_i & fpu_out_ready_o & tag_ok;
  always_comb begin
    busy_o = lock;
    for (int k = 0; k < NumReq; k++) begin
      inc[k] = in_hs & (g == IdxW'(k));
      dec[k] = out_hs & (fpu_tag_i == IdxW'(k)) & (cnt[k] != '0);
      busy_o = busy_o | (cnt[k] != '0);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock <= 1'b0;
      lock_g <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < NumReq; k++) cnt[k] <= '0;
    end else if (flush_i) begin
      lock <= 1'b0;
      lock_g <= '0;
      rr_ptr <= '0;
      for (int k = 0; k < NumReq; k++) cnt[k] <= '0;
    end else begin
      lock <= fpu_in_valid_o & ~fpu_in_ready_i;
      lock_g <= g;
      if (in_hs) rr_ptr <= (g == IdxW'(NumReq - 1)) ? '0 : g + 1'b1;
      for (int k = 0; k < NumReq; k++) begin
        if (inc[k] & ~dec[k]) cnt[k] <= cnt[k] + 1'b1;
        else if (dec[k] & ~inc[k]) cnt[k] <= cnt[k] - 1'b1;
      end
    end
  end
endmodule
